// File: rtl/ncpu32k_cell_skidbuf_pkg.sv
// Shared constants and helpers for the 2-entry skid buffer.
// Optional combinational bypass is selected by NCPU_SKIDBUF_BYPASS_EN.
package ncpu32k_cell_skidbuf_pkg;

  localparam int CNT_W = 2;

  function automatic logic [CNT_W-1:0] skid_occupancy(input logic main_vld, input logic skid_vld);
    return {1'b0, main_vld} + {1'b0, skid_vld};
  endfunction

endpackage

// File: rtl/ncpu32k_cell_skidbuf_if.sv
// Valid/ready stream bundle around the skid buffer: upstream (din side) and
// downstream (dout side). The buffer takes the slave modport.
interface ncpu32k_cell_skidbuf_if #(parameter int DW = 1);
  import ncpu32k_cell_skidbuf_pkg::*;

  logic [DW-1:0] din;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;

  modport master (output din, in_valid, out_ready, input in_ready, dout, out_valid);
  modport slave  (input din, in_valid, out_ready, output in_ready, dout, out_valid);

endinterface

// File: rtl/ncpu32k_cell_dff_lr.sv
// D flip-flop with load enable and asynchronous active-low reset to RST_VECTOR.
module ncpu32k_cell_dff_lr #(
  parameter int          DW         = 1,
  parameter logic [DW-1:0] RST_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VECTOR;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ncpu32k_cell_skidbuf.sv
// 2-entry skid buffer: registers in_ready to cut the backward ready chain.
// Define NCPU_SKIDBUF_BYPASS_EN for a zero-latency pass-through when empty.
module ncpu32k_cell_skidbuf
  import ncpu32k_cell_skidbuf_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ncpu32k_cell_skidbuf_if.slave  bus,
  output logic [CNT_W-1:0]       count
);

  logic          main_vld, skid_vld, rdy_q;
  logic [DW-1:0] main_q, skid_q;
  logic          push, pop;
  logic          main_vld_nxt, skid_vld_nxt;
  logic          main_ld, skid_ld;
  logic [DW-1:0] main_nxt;

  assign push = bus.in_valid & rdy_q;
  assign pop  = bus.out_valid & bus.out_ready;

`ifdef NCPU_SKIDBUF_BYPASS_EN
  // While empty the upstream beat is presented directly; it is only stored if not taken.
  logic bypass;
  assign bypass        = ~main_vld & ~flush;
  assign bus.out_valid = bypass ? bus.in_valid : main_vld;
  assign bus.dout      = bypass ? bus.din : main_q;
`else
  assign bus.out_valid = main_vld;
  assign bus.dout      = main_q;
`endif

  assign bus.in_ready = rdy_q;
  assign count        = skid_occupancy(main_vld, skid_vld);

  always_comb begin
    main_vld_nxt = main_vld;
    skid_vld_nxt = skid_vld;
    main_ld      = 1'b0;
    skid_ld      = 1'b0;
    main_nxt     = bus.din;
    if (flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (skid_vld) begin
      if (pop) begin
        skid_vld_nxt = 1'b0;
        main_ld      = 1'b1;
        main_nxt     = skid_q;
      end
    end else if (main_vld) begin
      if (push) begin
        if (pop) begin
          main_ld = 1'b1;
        end else begin
          skid_vld_nxt = 1'b1;
          skid_ld      = 1'b1;
        end
      end else if (pop) begin
        main_vld_nxt = 1'b0;
      end
    end else if (push) begin
      // pop can only be set here in the bypass build, where the beat has already left.
      main_vld_nxt = ~pop;
      main_ld      = 1'b1;
    end
  end

  ncpu32k_cell_dff_lr #(.DW(1)) u_main_vld (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .d(main_vld_nxt), .q(main_vld)
  );

  ncpu32k_cell_dff_lr #(.DW(1)) u_skid_vld (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .d(skid_vld_nxt), .q(skid_vld)
  );

  // Ready is kept as its own flop so upstream sees no logic after the register.
  ncpu32k_cell_dff_lr #(.DW(1), .RST_VECTOR(1'b1)) u_in_ready (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .d(~skid_vld_nxt), .q(rdy_q)
  );

  ncpu32k_cell_dff_lr #(.DW(DW)) u_main_dat (
    .clk(clk), .rst_n(rst_n), .load(main_ld), .d(main_nxt), .q(main_q)
  );

  ncpu32k_cell_dff_lr #(.DW(DW)) u_skid_dat (
    .clk(clk), .rst_n(rst_n), .load(skid_ld), .d(bus.din), .q(skid_q)
  );

endmodule

// File: tb/tb_ncpu32k_cell_skidbuf.sv
// Self-checking bench for ncpu32k_cell_skidbuf: vector table, reset corner,
// random scoreboard stress, and the NCPU_SKIDBUF_BYPASS_EN pass-through case.
module tb_ncpu32k_cell_skidbuf;
  import ncpu32k_cell_skidbuf_pkg::*;

  localparam int DW = 8;

  typedef struct {
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] din;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic          chk_dout;
    logic [DW-1:0] exp_dout;
    logic [1:0]    exp_count;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;

  ncpu32k_cell_skidbuf_if #(.DW(DW)) bus ();

  ncpu32k_cell_skidbuf #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  vec_t          vecs[$];
  logic [DW-1:0] sbQueue[$];
  int            assertCount = 0;
  int            failCount = 0;

  int            sz;
  logic          f, iv, ordy, expValid, pushM, popM, holdPending;
  logic [DW-1:0] d, heldDin, expFront;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic v, input logic [DW-1:0] data, input logic r);
    flush         = fl;
    bus.in_valid  = v;
    bus.din       = data;
    bus.out_ready = r;
  endtask

  function automatic void addVec(input logic fl, input logic v, input logic [DW-1:0] data,
                                 input logic r, input logic eir, input logic eov,
                                 input logic chk, input logic [DW-1:0] edout, input logic [1:0] ecnt);
    vec_t x;
    x.flush = fl; x.in_valid = v; x.din = data; x.out_ready = r;
    x.exp_in_ready = eir; x.exp_out_valid = eov; x.chk_dout = chk;
    x.exp_dout = edout; x.exp_count = ecnt;
    vecs.push_back(x);
  endfunction

  initial begin
    // Each row: inputs driven this cycle, outputs expected before the next rising edge.
    addVec(0, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    addVec(0, 1, 8'h11, 1, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'h22, 1, 1, 1, 1, 8'h11, 1);
    addVec(0, 1, 8'h33, 1, 1, 1, 1, 8'h22, 1);
    addVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h33, 1);
    addVec(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'hA1, 0, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'hA2, 0, 1, 1, 1, 8'hA1, 1);
    addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'hA1, 2);
    addVec(0, 0, 8'h00, 1, 0, 1, 1, 8'hA1, 2);
    addVec(0, 0, 8'h00, 1, 1, 1, 1, 8'hA2, 1);
    addVec(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'hB1, 0, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'hB2, 0, 1, 1, 1, 8'hB1, 1);
    addVec(1, 1, 8'h5C, 0, 0, 1, 1, 8'hB1, 2);
    addVec(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    addVec(0, 1, 8'hC1, 0, 1, 0, 0, 8'h00, 0);
    addVec(1, 1, 8'hC2, 1, 1, 1, 1, 8'hC1, 1);
    addVec(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    addVec(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0);

    applyStimulus(0, 0, '0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifndef NCPU_SKIDBUF_BYPASS_EN
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].din, vecs[i].out_ready);
      #1;
      checkOutput($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
      checkOutput($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      checkOutput($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      if (vecs[i].chk_dout)
        checkOutput($sformatf("row%0d dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
    end
`endif

    // Asynchronous reset while two beats are held.
    @(negedge clk); applyStimulus(0, 1, 8'h3C, 0);
    @(negedge clk); applyStimulus(0, 1, 8'h4D, 0);
    @(negedge clk); applyStimulus(0, 0, 8'h00, 0);
    #1;
    checkOutput("prerst count", 32'(count), 32'd2);
    checkOutput("prerst dout", 32'(bus.dout), 32'h3C);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst count", 32'(count), 32'd0);
    checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst dout", 32'(bus.dout), 32'h00);
    @(negedge clk); rst_n = 1'b1;

    holdPending = 1'b0;
    heldDin = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      f = ($urandom_range(99) < 2);
      if (holdPending) begin
        iv = 1'b1; d = heldDin;
      end else begin
        iv = 1'($urandom_range(1)); d = 8'($urandom);
      end
      ordy = 1'($urandom_range(1));
      applyStimulus(f, iv, d, ordy);
      #1;
      sz = sbQueue.size();
      expValid = (sz > 0);
      expFront = (sz > 0) ? sbQueue[0] : d;
`ifdef NCPU_SKIDBUF_BYPASS_EN
      if (sz == 0 && !f) expValid = iv;
`endif
      checkOutput("rnd count", 32'(count), 32'(sz));
      checkOutput("rnd in_ready", 32'(bus.in_ready), 32'(sz < 2));
      checkOutput("rnd out_valid", 32'(bus.out_valid), 32'(expValid));
      if (expValid) checkOutput("rnd dout order", 32'(bus.dout), 32'(expFront));
      #1 bus.out_ready = ~ordy;
      #1;
      checkOutput("rnd in_ready vs out_ready", 32'(bus.in_ready), 32'(sz < 2));
      bus.out_ready = ordy;
      pushM = iv && (sz < 2) && !f;
      popM  = expValid && ordy;
      if (pushM) sbQueue.push_back(d);
      if (popM) void'(sbQueue.pop_front());
      if (f) sbQueue.delete();
      holdPending = iv && !(sz < 2) && !f;
      heldDin = d;
    end

`ifdef NCPU_SKIDBUF_BYPASS_EN
    @(negedge clk); applyStimulus(1, 0, 8'h00, 0);
    @(negedge clk); applyStimulus(0, 1, 8'h7E, 1);
    #1;
    checkOutput("bypass out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bypass dout", 32'(bus.dout), 32'h7E);
    checkOutput("bypass count", 32'(count), 32'd0);
    @(negedge clk); applyStimulus(0, 0, 8'h00, 0);
    #1;
    checkOutput("bypass after count", 32'(count), 32'd0);
    checkOutput("bypass after out_valid", 32'(bus.out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
